// File: rtl/psum_accumulator.sv
// psum_accumulator: partial-sum stage ahead of the conv output buffer (write on first pass, read-add-write otherwise).
// Build option: define PSUM_SATURATE_EN to saturate accumulate-pass lane sums; by default they wrap.
`ifndef MAC_OUTPUT_WIDTH
`define MAC_OUTPUT_WIDTH 16
`endif

// state | meaning
// IDLE  | waiting for pass_start
// RUN   | accepting MAC beats until pass_length beats have been taken
// DRAIN | waiting until every write of the pass has been issued
module psum_accumulator #(
  parameter int MAC_OUTPUT_WIDTH    = `MAC_OUTPUT_WIDTH,
  parameter int BUFFER_READ_LATENCY = 3,
  parameter int LEN_WIDTH           = 15
) (
  input  logic                          system_clk,
  input  logic                          rst_n,
  input  logic                          pass_start,
  input  logic                          pass_first,
  input  logic [LEN_WIDTH-1:0]          pass_length,
  input  logic                          mac_valid,
  input  logic [MAC_OUTPUT_WIDTH*8-1:0] mac_data,
  output logic                          refresh_req,
  output logic                          adder_pulse,
  input  logic [MAC_OUTPUT_WIDTH*8-1:0] adder_feature,
  output logic [MAC_OUTPUT_WIDTH*8-1:0] feature_in,
  output logic                          feature_valid,
  output logic                          busy,
  output logic                          pass_done
);
  localparam int W   = MAC_OUTPUT_WIDTH;
  localparam int DW  = W * 8;
  localparam int LAT = BUFFER_READ_LATENCY;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic                 first_q, first_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [LEN_WIDTH-1:0] wr_q, wr_d;
  logic                 pass_done_q, pass_done_d;
  logic                 feature_valid_q, feature_valid_d;
  logic [DW-1:0]        feature_in_q, feature_in_d;
  logic [LAT-1:0]       dl_vld_q;
  logic [DW-1:0]        dl_dat_q [LAT];
  logic                 accept;
  logic [DW-1:0]        sum;

  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef PSUM_SATURATE_EN
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign accept        = (state_q == RUN) && mac_valid;
  assign refresh_req   = (state_q == IDLE) && pass_start;
  assign adder_pulse   = accept && !first_q;
  assign busy          = (state_q != IDLE);
  assign pass_done     = pass_done_q;
  assign feature_valid = feature_valid_q;
  assign feature_in    = feature_in_q;

  always_comb begin
    sum = '0;
    for (int k = 0; k < 8; k++)
      sum[k*W +: W] = lane_add(adder_feature[k*W +: W], dl_dat_q[LAT-1][k*W +: W]);
  end

  always_comb begin
    state_d         = state_q;
    first_d         = first_q;
    len_d           = len_q;
    beat_d          = beat_q;
    wr_d            = wr_q;
    pass_done_d     = 1'b0;
    feature_valid_d = 1'b0;
    feature_in_d    = feature_in_q;

    // A pass is either all first-pass or all accumulate, so the two write sources never collide.
    if (accept && first_q) begin
      feature_valid_d = 1'b1;
      feature_in_d    = mac_data;
    end else if (dl_vld_q[LAT-1]) begin
      feature_valid_d = 1'b1;
      feature_in_d    = sum;
    end
    if (feature_valid_d) wr_d = wr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pass_start) begin
          first_d = pass_first;
          len_d   = pass_length;
          beat_d  = '0;
          wr_d    = '0;
          state_d = (pass_length == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_q == len_q) begin
          pass_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      first_q         <= 1'b0;
      len_q           <= '0;
      beat_q          <= '0;
      wr_q            <= '0;
      pass_done_q     <= 1'b0;
      feature_valid_q <= 1'b0;
      feature_in_q    <= '0;
      dl_vld_q        <= '0;
      for (int i = 0; i < LAT; i++) dl_dat_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      first_q         <= first_d;
      len_q           <= len_d;
      beat_q          <= beat_d;
      wr_q            <= wr_d;
      pass_done_q     <= pass_done_d;
      feature_valid_q <= feature_valid_d;
      feature_in_q    <= feature_in_d;
      // Delay line lines each beat up with the buffer's read data LAT cycles after the pulse.
      dl_vld_q[0]     <= adder_pulse;
      dl_dat_q[0]     <= mac_data;
      for (int i = 1; i < LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_dat_q[i] <= dl_dat_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: random and directed passes against an output-buffer model and a golden partial-sum array.
`timescale 1ns/1ps
`ifndef MAC_OUTPUT_WIDTH
`define MAC_OUTPUT_WIDTH 16
`endif

module tb_psum_accumulator;
  localparam int W     = `MAC_OUTPUT_WIDTH;
  localparam int DW    = W * 8;
  localparam int LAT   = 3;
  localparam int LW    = 15;
  localparam int DEPTH = 64;

  logic          system_clk = 1'b0;
  logic          rst_n      = 1'b1;
  logic          pass_start = 1'b0;
  logic          pass_first = 1'b0;
  logic [LW-1:0] pass_length = '0;
  logic          mac_valid  = 1'b0;
  logic [DW-1:0] mac_data   = '0;
  logic          refresh_req, adder_pulse, feature_valid, busy, pass_done;
  logic [DW-1:0] adder_feature = '0;
  logic [DW-1:0] feature_in;

  psum_accumulator #(.MAC_OUTPUT_WIDTH(W), .BUFFER_READ_LATENCY(LAT), .LEN_WIDTH(LW)) dut (
    .system_clk(system_clk), .rst_n(rst_n), .pass_start(pass_start), .pass_first(pass_first),
    .pass_length(pass_length), .mac_valid(mac_valid), .mac_data(mac_data),
    .refresh_req(refresh_req), .adder_pulse(adder_pulse), .adder_feature(adder_feature),
    .feature_in(feature_in), .feature_valid(feature_valid), .busy(busy), .pass_done(pass_done)
  );

  always #5 system_clk = ~system_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_bus();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  // Reference lane arithmetic: exact integer sum, then clamp or keep the low W bits.
  function automatic logic [DW-1:0] model_acc(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] la, lb;
      longint s, lo, hi;
      la = a[k*W +: W];
      lb = b[k*W +: W];
      s  = longint'($signed(la)) + longint'($signed(lb));
      lo = -(longint'(1) << (W - 1));
      hi = (longint'(1) << (W - 1)) - 1;
`ifdef PSUM_SATURATE_EN
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`endif
      r[k*W +: W] = s[W-1:0];
    end
    return r;
  endfunction

  typedef struct { int cyc; logic [DW-1:0] data; } wr_t;

  logic [DW-1:0] bufmem [DEPTH];
  logic [DW-1:0] gold   [DEPTH];
  logic [DW-1:0] sched  [int];
  logic [DW-1:0] beat_dat [32];
  wr_t           expq [$];
  int            rd_ptr = 0, wr_ptr = 0;
  int            cyc = 0;
  int            done_cnt = 0, done_at = -1;
  logic          exp_refresh = 1'b0, exp_pulse = 1'b0;

  always @(posedge system_clk) cyc = cyc + 1;

  // Output buffer model (read-first) plus per-cycle comparison of the DUT's outputs.
  always @(negedge system_clk) begin
    wr_t w;
    if (rst_n) begin
      if (sched.exists(cyc)) begin
        adder_feature = sched[cyc];
        sched.delete(cyc);
      end else adder_feature = rand_bus();
      check("refresh_req", DW'(refresh_req), DW'(exp_refresh));
      check("adder_pulse", DW'(adder_pulse), DW'(exp_pulse));
      if (adder_pulse) begin
        sched[cyc + LAT] = bufmem[rd_ptr];
        rd_ptr = (rd_ptr + 1) % DEPTH;
      end
      if (feature_valid) begin
        bufmem[wr_ptr] = feature_in;
        wr_ptr = (wr_ptr + 1) % DEPTH;
        if (expq.size() == 0) check("unexpected_write", DW'(1), DW'(0));
        else begin
          w = expq.pop_front();
          check("write_cycle", DW'(cyc), DW'(w.cyc));
          check("write_data", feature_in, w.data);
        end
      end
      if (refresh_req) begin
        rd_ptr = 0;
        wr_ptr = 0;
      end
      if (pass_done) begin
        done_cnt++;
        done_at = cyc;
        check("busy_at_done", DW'(busy), DW'(0));
      end
    end
  end

  task automatic idle_cycle();
    @(posedge system_clk); #1;
    pass_start  = 1'b0;
    mac_valid   = 1'b0;
    mac_data    = rand_bus();
    exp_refresh = 1'b0;
    exp_pulse   = 1'b0;
  endtask

  // gap < 0 picks a random 0..2 idle cycles before each beat.
  task automatic run_pass(input bit first, input int len, input int nbeats, input int gap, input bit extra_start);
    int  start_c, last_w, acc, d0, exp_done, g;
    wr_t w;
    d0 = done_cnt; last_w = 0; acc = 0;
    @(posedge system_clk); #1;
    pass_start  = 1'b1;
    pass_first  = first;
    pass_length = LW'(len);
    mac_valid   = 1'b1;
    mac_data    = rand_bus();
    exp_refresh = 1'b1;
    exp_pulse   = 1'b0;
    start_c     = cyc;
    for (int i = 0; i < nbeats; i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) idle_cycle();
      @(posedge system_clk); #1;
      pass_start  = extra_start && (i == 1);
      pass_first  = extra_start ? 1'($urandom) : first;
      pass_length = extra_start ? LW'($urandom_range(20, 1)) : pass_length;
      mac_valid   = 1'b1;
      mac_data    = beat_dat[i];
      exp_refresh = 1'b0;
      if (acc < len) begin
        exp_pulse = !first;
        w.cyc  = cyc + (first ? 1 : LAT + 1);
        w.data = first ? mac_data : model_acc(gold[acc], mac_data);
        gold[acc] = w.data;
        expq.push_back(w);
        last_w = w.cyc;
        acc++;
      end else exp_pulse = 1'b0;
    end
    idle_cycle();
    exp_done = (len == 0) ? start_c + 2 : last_w + 1;
    for (int t = 0; t < 100 && done_cnt == d0; t++) begin
      @(negedge system_clk); #1;
    end
    repeat (3) idle_cycle();
    check("pass_done_count", DW'(done_cnt - d0), DW'(1));
    check("pass_done_cycle", DW'(done_at), DW'(exp_done));
    check("writes_pending", DW'(expq.size()), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] mx, mn;
    mx = {1'b0, {(W-1){1'b1}}};
    mn = {1'b1, {(W-1){1'b0}}};
    for (int i = 0; i < DEPTH; i++) begin
      bufmem[i] = '0;
      gold[i]   = '0;
    end

    #1 rst_n = 1'b0;
    repeat (2) @(posedge system_clk);
    #2;
    check("rst_feature_in", feature_in, '0);
    check("rst_feature_valid", DW'(feature_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_pass_done", DW'(pass_done), DW'(0));
    check("rst_adder_pulse", DW'(adder_pulse), DW'(0));
    check("rst_refresh_req", DW'(refresh_req), DW'(0));
    @(negedge system_clk) rst_n = 1'b1;

    // First pass, lane0 = 1..4 back to back.
    for (int i = 0; i < 4; i++) beat_dat[i] = DW'(i + 1);
    run_pass(1'b1, 4, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) check("first_pass_lane0", DW'(bufmem[i][W-1:0]), DW'(i + 1));

    // Stored 10,20,30,40 then accumulate 1,2,3,4.
    for (int i = 0; i < 4; i++) beat_dat[i] = DW'(10 * (i + 1));
    run_pass(1'b1, 4, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) beat_dat[i] = DW'(i + 1);
    run_pass(1'b0, 4, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) check("accum_lane0", DW'(bufmem[i][W-1:0]), DW'(11 * (i + 1)));

    // Gapped accumulate beats, one every 3 cycles.
    for (int i = 0; i < 5; i++) beat_dat[i] = rand_bus();
    run_pass(1'b0, 5, 5, 2, 1'b0);

    // Lane0 boundary: max + 1.
    beat_dat[0] = rand_bus();
    beat_dat[0][W-1:0] = mx;
    run_pass(1'b1, 1, 1, 0, 1'b0);
    beat_dat[0] = rand_bus();
    beat_dat[0][W-1:0] = W'(1);
    run_pass(1'b0, 1, 1, 0, 1'b0);
`ifdef PSUM_SATURATE_EN
    check("boundary_lane0", DW'(bufmem[0][W-1:0]), DW'(mx));
`else
    check("boundary_lane0", DW'(bufmem[0][W-1:0]), DW'(mn));
`endif

    // Extra beats dropped and a pass_start during RUN ignored; then an empty pass.
    for (int i = 0; i < 4; i++) beat_dat[i] = rand_bus();
    run_pass(1'b0, 2, 4, 0, 1'b1);
    run_pass(1'b1, 0, 2, 0, 1'b0);

    // Reset in the middle of an accumulate pass.
    @(posedge system_clk); #1;
    pass_start = 1'b1; pass_first = 1'b0; pass_length = LW'(8);
    mac_valid = 1'b0; exp_refresh = 1'b1; exp_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge system_clk); #1;
      pass_start = 1'b0; mac_valid = 1'b1; mac_data = rand_bus();
      exp_refresh = 1'b0; exp_pulse = 1'b1;
    end
    @(posedge system_clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_feature_in", feature_in, '0);
    check("midrst_feature_valid", DW'(feature_valid), DW'(0));
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_pass_done", DW'(pass_done), DW'(0));
    check("midrst_adder_pulse", DW'(adder_pulse), DW'(0));
    check("midrst_refresh_req", DW'(refresh_req), DW'(0));
    mac_valid = 1'b0; exp_pulse = 1'b0; exp_refresh = 1'b0;
    sched.delete();
    expq.delete();
    repeat (2) @(posedge system_clk);
    @(negedge system_clk) rst_n = 1'b1;
    #1 check("post_rst_idle", DW'(busy), DW'(0));
    for (int i = 0; i < 4; i++) beat_dat[i] = rand_bus();
    run_pass(1'b0, 4, 4, 0, 1'b0);

    // Random passes.
    for (int p = 0; p < 10; p++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < 16; i++) beat_dat[i] = rand_bus();
      run_pass(1'($urandom), len, len + int'($urandom_range(2, 0)), -1, 1'b0);
    end

    for (int i = 0; i < 16; i++) check("buffer_contents", bufmem[i], gold[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
